reg_op_scheduler: RTL



---
 rtl/reg_sched_pkg.sv | 26 ++
 rtl/rr_arbiter.sv | 28 ++
 rtl/reg_op_scheduler.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/reg_sched_pkg.sv
// Shared types for the register operation scheduler: op codes and FSM states.
package reg_sched_pkg;

  typedef enum logic [2:0] {
    OP_READ = 3'b000,
    OP_LOAD = 3'b001,
    OP_INC  = 3'b010,
    OP_DEC  = 3'b011,
    OP_INCW = 3'b100,
    OP_DECW = 3'b101,
    OP_SHR  = 3'b110,
    OP_SHL  = 3'b111
  } reg_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    RESP = 2'b10
  } sched_state_e;

  // READ and LOAD always take one cycle regardless of the repeat count.
  function automatic logic op_is_single(reg_op_e op);
    return (op == OP_READ) || (op == OP_LOAD);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: priority starts at last+1 and wraps modulo N.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx
);

  // Scan from the lowest priority upward so the nearest requester after last wins.
  always_comb begin
    logic [IW-1:0] idx;
    grant     = '0;
    grant_idx = '0;
    idx       = '0;
    for (int k = N; k >= 1; k--) begin
      idx = IW'((int'(last) + k) % N);
      if (req[idx]) begin
        grant      = '0;
        grant[idx] = 1'b1;
        grant_idx  = idx;
      end
    end
  end

endmodule

// File: rtl/reg_op_scheduler.sv
// Shares one load/shift/inc/dec register between NREQ requesters: round-robin accept,
// sequence the register controls for the op's cycle count, then strobe the result.
module reg_op_scheduler
  import reg_sched_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int DEPTH = 5,
  parameter int CNTW  = 3
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [NREQ-1:0]          req_valid,
  output logic [NREQ-1:0]          req_ready,
  input  logic [NREQ*3-1:0]        req_op,
  input  logic [NREQ*CNTW-1:0]     req_cnt,
  input  logic [NREQ*DEPTH-1:0]    req_data,
  output logic                     rsp_valid,
  output logic [$clog2(NREQ)-1:0]  rsp_id,
  output logic [DEPTH-1:0]         rsp_data,
  output logic                     reg_load,
  output logic                     reg_shr,
  output logic                     reg_shl,
  output logic                     reg_inc,
  output logic                     reg_dec,
  output logic                     reg_loop,
  output logic                     reg_logshift,
  output logic [DEPTH-1:0]         reg_in,
  input  logic [DEPTH-1:0]         reg_out
);

  localparam int IDW = $clog2(NREQ);

  reg_op_e          op_arr   [NREQ];
  logic [CNTW-1:0]  cnt_arr  [NREQ];
  logic [DEPTH-1:0] data_arr [NREQ];

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_slice
    assign op_arr[gi]   = reg_op_e'(req_op[gi*3 +: 3]);
    assign cnt_arr[gi]  = req_cnt[gi*CNTW +: CNTW];
    assign data_arr[gi] = req_data[gi*DEPTH +: DEPTH];
  end

  sched_state_e     state;
  sched_state_e     state_next;
  logic [IDW-1:0]   last_grant;
  reg_op_e          op_cur;
  logic [DEPTH-1:0] data_cur;
  logic [IDW-1:0]   id_cur;
  logic [CNTW-1:0]  cnt_left;

  logic [NREQ-1:0]  grant;
  logic [IDW-1:0]   grant_idx;
  logic             accept;
  reg_op_e          sel_op;
  logic [CNTW-1:0]  sel_cnt;
  logic [CNTW-1:0]  sel_left;

  rr_arbiter #(.N(NREQ)) u_arb (
    .req       (req_valid),
    .last      (last_grant),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  assign accept  = (state == IDLE) && (|req_valid);
  assign sel_op  = op_arr[grant_idx];
  assign sel_cnt = cnt_arr[grant_idx];

  // Counter holds remaining EXEC cycles minus one; cnt=0 behaves like cnt=1.
  always_comb begin
    sel_left = '0;
    if (!op_is_single(sel_op) && (sel_cnt != '0)) begin
      sel_left = sel_cnt - CNTW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = EXEC;
      EXEC:    if (cnt_left == '0) state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_grant <= IDW'(NREQ - 1);
      op_cur     <= OP_READ;
      data_cur   <= '0;
      id_cur     <= '0;
      cnt_left   <= '0;
    end else if (accept) begin
      last_grant <= grant_idx;
      op_cur     <= sel_op;
      data_cur   <= data_arr[grant_idx];
      id_cur     <= grant_idx;
      cnt_left   <= sel_left;
    end else if ((state == EXEC) && (cnt_left != '0)) begin
      cnt_left   <= cnt_left - CNTW'(1);
    end
  end

  // Register controls and response come from registered state only; req_ready is the lone
  // output that looks at req_valid directly.
  always_comb begin
    req_ready    = '0;
    rsp_valid    = 1'b0;
    rsp_id       = '0;
    rsp_data     = '0;
    reg_load     = 1'b0;
    reg_shr      = 1'b0;
    reg_shl      = 1'b0;
    reg_inc      = 1'b0;
    reg_dec      = 1'b0;
    reg_loop     = 1'b0;
    reg_logshift = 1'b0;
    reg_in       = '0;
    case (state)
      IDLE: req_ready = grant;
      EXEC: begin
        case (op_cur)
          OP_LOAD: begin
            reg_load = 1'b1;
            reg_in   = data_cur;
          end
          OP_INC:  reg_inc = 1'b1;
          OP_DEC:  reg_dec = 1'b1;
          OP_INCW: begin
            reg_inc  = 1'b1;
            reg_loop = 1'b1;
          end
          OP_DECW: begin
            reg_dec  = 1'b1;
            reg_loop = 1'b1;
          end
          OP_SHR: begin
            reg_shr      = 1'b1;
            reg_logshift = 1'b1;
          end
          OP_SHL: begin
            reg_shl      = 1'b1;
            reg_logshift = 1'b1;
          end
          default: ;
        endcase
      end
      RESP: begin
        rsp_valid = 1'b1;
        rsp_id    = id_cur;
        rsp_data  = reg_out;
      end
      default: ;
    endcase
  end

endmodule
